// File: rtl/issue_rat_pkg.sv
// Shared types for the rename-stage FGR controller: tag width default, tag type, FSM states.
package issue_rat_pkg;

  localparam int unsigned FGR_WIDTH_DEFAULT = 3;

  typedef logic [FGR_WIDTH_DEFAULT-1:0] fgr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } fgr_ctrl_state_t;

endpackage

// File: rtl/issue_rat_fgr_walker.sv
// Abandon-walk pointer and target registers, with age comparison relative to the queue head.
module issue_rat_fgr_walker
  import issue_rat_pkg::*;
#(
  parameter int unsigned FGR_WIDTH = FGR_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 start,
  input  logic [FGR_WIDTH-1:0] start_target,
  input  logic [FGR_WIDTH-1:0] start_walk,
  input  logic [FGR_WIDTH-1:0] head,
  input  logic                 mispredict_valid,
  input  logic [FGR_WIDTH-1:0] resolve_fgr,
  output logic [FGR_WIDTH-1:0] walk,
  output logic [FGR_WIDTH-1:0] target,
  output logic                 resolve_older_c,
  output logic                 redirect_c,
  output logic                 done_c
);

  logic [FGR_WIDTH-1:0] res_off;
  logic [FGR_WIDTH-1:0] tgt_off;

  // Age is the distance from head; smaller distance means older.
  always_comb begin
    res_off         = resolve_fgr - head;
    tgt_off         = target - head;
    resolve_older_c = res_off < tgt_off;
    redirect_c      = active && mispredict_valid && resolve_older_c;
    done_c          = active && !redirect_c && (walk == target);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      walk   <= '0;
      target <= '0;
    end else if (start) begin
      walk   <= start_walk;
      target <= start_target;
    end else if (active) begin
      if (redirect_c) target <= resolve_fgr;
      if (!done_c)    walk   <= walk - FGR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/issue_rat_fgr_ctrl.sv
// FGR allocation/commit/abandon controller driving the rename free list in program order.
// Optional protocol error flag enabled by defining ISSUE_RAT_FGR_CTRL_ERRCHK_EN.
module issue_rat_fgr_ctrl
  import issue_rat_pkg::*;
#(
  parameter int unsigned FGR_WIDTH = FGR_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_alloc_valid,
  output logic                 o_alloc_ready,
  output logic [FGR_WIDTH-1:0] o_alloc_fgr,
  output logic [FGR_WIDTH-1:0] o_cur_fgr,
  output logic                 o_cur_speculative,
  input  logic                 i_resolve_valid,
  input  logic [FGR_WIDTH-1:0] i_resolve_fgr,
  input  logic                 i_resolve_mispredict,
  output logic                 o_commit_valid,
  output logic [FGR_WIDTH-1:0] o_commit_fgr,
  output logic                 o_abandon_valid,
  output logic [FGR_WIDTH-1:0] o_abandon_fgr,
  output logic                 o_busy,
  output logic                 o_error
);

  localparam int unsigned PW    = FGR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << FGR_WIDTH;

  fgr_ctrl_state_t      state, state_d;
  logic [PW-1:0]        head, head_d, tail, tail_d;
  logic [DEPTH-1:0]     resolved_ok, resolved_ok_d;

  logic [FGR_WIDTH-1:0] head_low, res_off, walk, target, start_walk;
  logic [PW-1:0]        count, tail_alloc, tail_m1, tail_cur_m1, term_tail;
  logic                 empty, full, walking, res_live, res_done;
  logic                 alloc_fire, commit_fire, res_ok, mispredict, start;
  logic                 resolve_older_c, redirect_c, done_c;

  always_comb begin
    head_low    = head[FGR_WIDTH-1:0];
    count       = tail - head;
    empty       = head == tail;
    full        = (head_low == tail[FGR_WIDTH-1:0]) && (head[FGR_WIDTH] != tail[FGR_WIDTH]);
    walking     = state == WALK;
    res_off     = i_resolve_fgr - head_low;
    res_live    = {1'b0, res_off} < count;
    res_done    = resolved_ok[i_resolve_fgr];
    alloc_fire  = i_alloc_valid && o_alloc_ready;
    commit_fire = !empty && resolved_ok[head_low];
    tail_alloc  = tail + PW'(alloc_fire);
    tail_m1     = tail_alloc - PW'(1);
    start_walk  = tail_m1[FGR_WIDTH-1:0];
    mispredict  = i_resolve_valid && i_resolve_mispredict && !res_done;
    start       = !walking && mispredict && res_live;
    // During a walk only tags older than the target may still be recorded.
    res_ok      = i_resolve_valid && !i_resolve_mispredict && res_live &&
                  (!walking || resolve_older_c);
    term_tail   = head + PW'(target - head_low);
    tail_cur_m1 = tail - PW'(1);
  end

  issue_rat_fgr_walker #(.FGR_WIDTH(FGR_WIDTH)) u_walker (
    .clk              (clk),
    .reset            (reset),
    .active           (walking),
    .start            (start),
    .start_target     (i_resolve_fgr),
    .start_walk       (start_walk),
    .head             (head_low),
    .mispredict_valid (mispredict),
    .resolve_fgr      (i_resolve_fgr),
    .walk             (walk),
    .target           (target),
    .resolve_older_c  (resolve_older_c),
    .redirect_c       (redirect_c),
    .done_c           (done_c)
  );

  // Next-state: queue pointers, resolved bits and walk FSM.
  always_comb begin
    state_d       = state;
    head_d        = head + PW'(commit_fire);
    tail_d        = tail_alloc;
    resolved_ok_d = resolved_ok;
    if (res_ok)     resolved_ok_d[i_resolve_fgr]         = 1'b1;
    if (alloc_fire) resolved_ok_d[tail[FGR_WIDTH-1:0]]   = 1'b0;
    case (state)
      IDLE: if (start) state_d = WALK;
      WALK: begin
        if (done_c) begin
          state_d = IDLE;
          tail_d  = term_tail;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      resolved_ok <= '0;
    end else begin
      state       <= state_d;
      head        <= head_d;
      tail        <= tail_d;
      resolved_ok <= resolved_ok_d;
    end
  end

`ifdef ISSUE_RAT_FGR_CTRL_ERRCHK_EN
  logic error_q;
  logic error_d;

  always_comb begin
    error_d = error_q;
    if (!walking && i_resolve_valid && !res_live) error_d = 1'b1;
    if (i_alloc_valid && !o_alloc_ready)          error_d = 1'b1;
    if (i_resolve_valid && res_live && res_done)  error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  // Outputs decode registered state only.
  assign o_alloc_ready     = !walking && !full;
  assign o_alloc_fgr       = tail[FGR_WIDTH-1:0];
  assign o_cur_fgr         = empty ? '0 : tail_cur_m1[FGR_WIDTH-1:0];
  assign o_cur_speculative = !empty;
  assign o_commit_valid    = commit_fire;
  assign o_commit_fgr      = commit_fire ? head_low : '0;
  assign o_abandon_valid   = walking;
  assign o_abandon_fgr     = walking ? walk : '0;
  assign o_busy            = walking;

endmodule

// File: tb/tb_issue_rat_fgr_ctrl.sv
// Directed self-checking bench for issue_rat_fgr_ctrl (default FGR_WIDTH = 3).
module tb_issue_rat_fgr_ctrl;
  import issue_rat_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_alloc_valid = 1'b0;
  logic i_resolve_valid = 1'b0;
  fgr_t i_resolve_fgr = '0;
  logic i_resolve_mispredict = 1'b0;
  logic o_alloc_ready, o_cur_speculative, o_commit_valid, o_abandon_valid, o_busy, o_error;
  fgr_t o_alloc_fgr, o_cur_fgr, o_commit_fgr, o_abandon_fgr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  issue_rat_fgr_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .i_alloc_valid        (i_alloc_valid),
    .o_alloc_ready        (o_alloc_ready),
    .o_alloc_fgr          (o_alloc_fgr),
    .o_cur_fgr            (o_cur_fgr),
    .o_cur_speculative    (o_cur_speculative),
    .i_resolve_valid      (i_resolve_valid),
    .i_resolve_fgr        (i_resolve_fgr),
    .i_resolve_mispredict (i_resolve_mispredict),
    .o_commit_valid       (o_commit_valid),
    .o_commit_fgr         (o_commit_fgr),
    .o_abandon_valid      (o_abandon_valid),
    .o_abandon_fgr        (o_abandon_fgr),
    .o_busy               (o_busy),
    .o_error              (o_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs are set for the coming edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_alloc_valid        = 1'b0;
    i_resolve_valid      = 1'b0;
    i_resolve_fgr        = '0;
    i_resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    i_alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    i_alloc_valid = 1'b0;
  endtask

  task automatic resolve(input int fgr, input logic mp);
    i_resolve_valid      = 1'b1;
    i_resolve_fgr        = fgr_t'(fgr);
    i_resolve_mispredict = mp;
  endtask

  task automatic expect_walk(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_abandon_valid"}, 32'(o_abandon_valid), 32'd1);
      chk({tag, "_abandon_fgr"}, 32'(o_abandon_fgr), 32'((first - i) & 7));
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      chk({tag, "_ready_low"}, 32'(o_alloc_ready), 32'd0);
      tick();
    end
    chk({tag, "_walk_end"}, 32'(o_abandon_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ready", 32'(o_alloc_ready), 32'd1);
    chk("rst_alloc_fgr", 32'(o_alloc_fgr), 32'd0);
    chk("rst_cur_fgr", 32'(o_cur_fgr), 32'd0);
    chk("rst_spec", 32'(o_cur_speculative), 32'd0);
    chk("rst_commit", 32'(o_commit_valid), 32'd0);
    chk("rst_abandon", 32'(o_abandon_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);

    // Fill and full
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready", 32'(o_alloc_ready), 32'd1);
      chk("fill_grant", 32'(o_alloc_fgr), 32'(i));
      i_alloc_valid = 1'b1;
      tick();
    end
    i_alloc_valid = 1'b0;
    chk("full_ready", 32'(o_alloc_ready), 32'd0);
    chk("full_cur_fgr", 32'(o_cur_fgr), 32'd7);
    chk("full_spec", 32'(o_cur_speculative), 32'd1);

    // In-order commit
    do_reset();
    alloc_n(4);
    resolve(2, 1'b0); tick();
    chk("ord_no_commit_a", 32'(o_commit_valid), 32'd0);
    resolve(1, 1'b0); tick();
    chk("ord_no_commit_b", 32'(o_commit_valid), 32'd0);
    resolve(0, 1'b0); tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("ord_commit_valid", 32'(o_commit_valid), 32'd1);
      chk("ord_commit_fgr", 32'(o_commit_fgr), 32'(i));
      tick();
    end
    chk("ord_commit_done", 32'(o_commit_valid), 32'd0);
    chk("ord_cur_fgr", 32'(o_cur_fgr), 32'd3);
    chk("ord_spec", 32'(o_cur_speculative), 32'd1);
    chk("ord_error", 32'(o_error), 32'd0);

    // Abandon walk
    do_reset();
    alloc_n(6);
    resolve(2, 1'b1); tick();
    idle_inputs();
    expect_walk("walk", 5, 4);
    chk("walk_ready", 32'(o_alloc_ready), 32'd1);
    chk("walk_next_grant", 32'(o_alloc_fgr), 32'd2);
    chk("walk_cur_fgr", 32'(o_cur_fgr), 32'd1);

    // Wrap: head = 6, tail = 2 with wrap bit set
    do_reset();
    alloc_n(8);
    for (int i = 0; i < 6; i++) begin
      resolve(i, 1'b0);
      tick();
    end
    idle_inputs();
    tick();
    chk("wrap_drained", 32'(o_commit_valid), 32'd0);
    chk("wrap_grant0", 32'(o_alloc_fgr), 32'd0);
    alloc_n(2);
    chk("wrap_cur_fgr", 32'(o_cur_fgr), 32'd1);
    resolve(7, 1'b1); tick();
    idle_inputs();
    expect_walk("wrap", 1, 3);
    chk("wrap_next_grant", 32'(o_alloc_fgr), 32'd7);
    chk("wrap_after_cur", 32'(o_cur_fgr), 32'd6);

    // Nested mispredict redirects the target without repeating abandons
    do_reset();
    alloc_n(6);
    resolve(4, 1'b1); tick();
    chk("nest_first_fgr", 32'(o_abandon_fgr), 32'd5);
    resolve(1, 1'b1); tick();
    idle_inputs();
    expect_walk("nest", 4, 4);
    chk("nest_next_grant", 32'(o_alloc_fgr), 32'd1);

    // Allocation and mispredict in the same cycle
    do_reset();
    alloc_n(2);
    chk("sim_ready", 32'(o_alloc_ready), 32'd1);
    i_alloc_valid = 1'b1;
    resolve(0, 1'b1); tick();
    idle_inputs();
    expect_walk("sim", 2, 3);
    chk("sim_next_grant", 32'(o_alloc_fgr), 32'd0);
    chk("sim_spec", 32'(o_cur_speculative), 32'd0);
    chk("sim_error", 32'(o_error), 32'd0);

    // Reset mid-walk
    do_reset();
    alloc_n(4);
    resolve(1, 1'b1); tick();
    idle_inputs();
    chk("rw_abandon_first", 32'(o_abandon_fgr), 32'd3);
    reset = 1'b1;
    tick();
    chk("rw_no_abandon", 32'(o_abandon_valid), 32'd0);
    chk("rw_busy", 32'(o_busy), 32'd0);
    chk("rw_ready", 32'(o_alloc_ready), 32'd1);
    chk("rw_spec", 32'(o_cur_speculative), 32'd0);
    reset = 1'b0;
    tick();

    // Resolve of a non-live tag
    resolve(3, 1'b0); tick();
    idle_inputs();
`ifdef ISSUE_RAT_FGR_CTRL_ERRCHK_EN
    chk("err_set", 32'(o_error), 32'd1);
    tick();
    chk("err_sticky", 32'(o_error), 32'd1);
`else
    chk("err_tied", 32'(o_error), 32'd0);
`endif
    chk("err_no_commit", 32'(o_commit_valid), 32'd0);
    chk("err_still_empty", 32'(o_cur_speculative), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_rat_fgr_ctrl.md
# issue_rat_fgr_ctrl

Controller for the rename-stage free list. It allocates speculative group tags (FGRs) to branches and tracks their resolution in an 8-entry circular order queue. It drives the free list's `acquire_fgr`, `commit` and `abandon` inputs in program order. On a misprediction it walks the abandoned groups youngest-first, one per cycle, so the free list can reclaim their PRFs.

## Interface
- `FGR_WIDTH`, default 3: tag width; queue depth is 2^FGR_WIDTH = 8.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_alloc_valid`  in  1  request a new FGR (branch renamed).
- `o_alloc_ready`  out  1  allocation accepted this cycle when both valid and ready are high.
- `o_alloc_fgr`  out  FGR_WIDTH  tag granted, equal to the tail pointer.
- `o_cur_fgr`  out  FGR_WIDTH  youngest live FGR (tail−1); drives the free list `i_acquire_fgr`.
- `o_cur_speculative`  out  1  at least one live FGR; drives the free list `i_acquire_fgr_speculative`.
- `i_resolve_valid`  in  1  branch resolution strobe.
- `i_resolve_fgr`  in  FGR_WIDTH  resolved tag.
- `i_resolve_mispredict`  in  1  1 = mispredicted, 0 = correct.
- `o_commit_valid`  out  1  to the free list `i_commit_valid`.
- `o_commit_fgr`  out  FGR_WIDTH  to the free list `i_commit_fgr`.
- `o_abandon_valid`  out  1  to the free list `i_abandon_valid`.
- `o_abandon_fgr`  out  FGR_WIDTH  to the free list `i_abandon_fgr`.
- `o_busy`  out  1  abandon walk in progress.
- `o_error`  out  1  sticky protocol error flag (see Configuration).

## Operation
- **Queue pointers:** `head` and `tail` are FGR_WIDTH+1 bits, with a wrap bit.
  - Empty when `head == tail`.
  - Full when the low bits are equal and the wrap bits differ.
- **Per-entry state:** each entry holds a `resolved_ok` bit. Live entries are those from `head` up to, but not including, `tail`.
- **Allocation:**
  - `o_alloc_ready = (state == IDLE) && !full`.
  - On accept: `tail` increments and the entry's `resolved_ok` is cleared.
- **Correct resolve** of a live tag sets its `resolved_ok` bit.
- **Resolve of a non-live tag** is ignored.
- **Commit:**
  - `o_commit_valid` is high when the head entry is live and `resolved_ok` is set. `o_commit_fgr` is `head`.
  - `head` increments in the same cycle.
  - At most one commit per cycle, strictly in order.
- **States:**
  - `IDLE`: a mispredict resolve of live tag X moves to `WALK`, with `target = X` and `walk = tail − 1`. Here `tail` is the post-update value, so an allocation accepted in the same cycle is included in the walk.
  - `WALK`, each cycle:
    - `o_abandon_valid = 1` and `o_abandon_fgr = walk`.
    - If `walk == target`: `tail ← target`, go to `IDLE`.
    - Otherwise `walk` decrements (mod 2^FGR_WIDTH).
- **During WALK:**
  - `o_alloc_ready = 0` and `o_busy = 1`.
  - A mispredict for a live tag older than `target` updates `target` to that tag. The walk continues from the current `walk` value.
  - Resolves (correct or mispredict) for tags at or younger than `target` are ignored.
  - Correct resolves for older tags are recorded.
- **Commit during WALK:** commit continues concurrently for entries older than `target`. The target entry never carries `resolved_ok`, so the head cannot pass it.
- **`o_cur_fgr`** is the low bits of `tail − 1`. `o_cur_speculative = !empty`.

## Timing
- **Reset values:** all outputs 0, except `o_alloc_ready = 1`. After reset: `head = tail = 0`, state `IDLE`, all `resolved_ok` bits cleared, `o_error` cleared.
- **Reset during WALK** terminates the walk immediately. No further abandons are emitted.
- **Outputs:**
  - Commit, abandon, cur and busy outputs are decoded from registers only, with no combinational input-to-output path.
  - `o_alloc_ready` also depends on registers only.
- **Latencies:**
  - Correct resolve of the head in cycle N: `o_commit_valid` in cycle N+1.
  - Mispredict in cycle N: the first abandon is in cycle N+1.
  - A walk over k entries lasts k cycles; `o_alloc_ready` returns in cycle N+k+1 (if not full).
- **Wrap-around:** pointer arithmetic is modulo 2^(FGR_WIDTH+1). The walk pointer wraps from 0 to 7.

## Configuration
- **`ISSUE_RAT_FGR_CTRL_ERRCHK_EN` defined:** `o_error` is set, and stays set until reset, on any of:
  - a resolve for a non-live tag while in `IDLE`;
  - `i_alloc_valid` while `o_alloc_ready = 0`;
  - a second resolve of an already-resolved tag.
- **Not defined:** `o_error` is tied to 0 and the check logic is absent. Functional behaviour is otherwise identical.

## Structure
- **Shared package `issue_rat_pkg`:**
  - `FGR_WIDTH` default;
  - the `fgr_t` typedef;
  - the state enum `fgr_ctrl_state_t` (`IDLE`, `WALK`).
- **One sub-module, `issue_rat_fgr_walker`:** holds the `walk`/`target` registers, older-than comparison and termination, relative to `head`.

## Test plan
- **Fill and full:** reset, then allocate 8 times → tags 0..7 granted, `o_alloc_ready = 0` at count 8, `o_cur_fgr = 7`, `o_cur_speculative = 1`.
- **In-order commit:** allocate 0..3; resolve correct 2, 1, 0 on consecutive cycles → commits 0, 1, 2 on consecutive cycles, only after 0 resolves; 3 is still live.
- **Abandon walk:** allocate 0..5; mispredict 2 → abandons 5, 4, 3, 2 on consecutive cycles, `o_busy` for 4 cycles; then `o_alloc_ready = 1` and the next grant is 2.
- **Wrap:** commit and allocate until `head = 6`, `tail = 2` (wrapped); mispredict 7 → abandons 1, 0, 7.
- **Nested mispredict:** allocate 0..5; mispredict 4, then mispredict 1 in the cycle after → abandons 5, 4, 3, 2, 1 with no repeats.
- **Simultaneous events, reset, error flag:**
  - Alloc and mispredict 0 in the same cycle with `tail = 2` → the new tag 2 is abandoned first.
  - Reset mid-walk → no abandon in the following cycle.
  - With `ISSUE_RAT_FGR_CTRL_ERRCHK_EN`, resolving a non-live tag sets `o_error = 1`.
